// File: rtl/multicycle_control_if.sv
// Bundle of instruction-register fields, ALU flag, memory handshake and
// all datapath control strobes exchanged with the multi-cycle control unit.
interface multicycle_control_if;
    // Instruction fields and datapath status
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    // Memory port control
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;

    // Instruction register and PC control
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_inv;
    logic [1:0] pc_source;

    // ALU control
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;

    // Register file control
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;

    // Status
    logic       syscall;
    logic       bus_error;
    logic       illegal;
    logic       halted;
    logic [3:0] state;

    // Control unit side
    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_read, mem_write, i_or_d,
        output ir_write, pc_write, pc_write_cond, pc_write_cond_inv, pc_source,
        output alu_op, alu_src_a, alu_src_b, zero_ext,
        output reg_write, reg_dst, mem_to_reg,
        output syscall, bus_error, illegal, halted, state
    );

    // Datapath / memory side
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_read, mem_write, i_or_d,
        input  ir_write, pc_write, pc_write_cond, pc_write_cond_inv, pc_source,
        input  alu_op, alu_src_a, alu_src_b, zero_ext,
        input  reg_write, reg_dst, mem_to_reg,
        input  syscall, bus_error, illegal, halted, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-style control unit: sequences fetch, decode, execute,
// memory and write-back over a shared datapath and a single memory port.
// Memory accesses stall on mem_ready and time out after MAX_WAIT idle cycles;
// undecodable instructions and timeouts park the unit in TRAP until reset.
module multicycle_control #(
    parameter bit ENABLE_BNE  = 1'b1,
    parameter bit ENABLE_ORI  = 1'b1,
    parameter bit ENABLE_JUMP = 1'b1,
    parameter int MAX_WAIT    = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    // State encodings (also exported on the debug port)
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_I_EXEC    = 4'd10;
    localparam logic [3:0] S_I_WB      = 4'd11;
    localparam logic [3:0] S_TRAP      = 4'd12;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FUNCT_SYSCALL = 6'b001100;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Supported R-type functs and the ALU operation each one selects
    localparam int         N_RFUNCT = 5;
    localparam logic [N_RFUNCT-1:0][5:0] R_FUNCTS = {
        6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010
    };
    localparam logic [N_RFUNCT-1:0][2:0] R_ALUOPS = {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    };

    // Wait counter sized to hold MAX_WAIT
    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam bit TIMEOUT_EN = (MAX_WAIT != 0);

    logic [3:0]        state_reg;
    logic [3:0]        state_next;
    logic [WAIT_W-1:0] wait_reg;
    logic [WAIT_W-1:0] wait_next;
    logic              bus_error_reg;
    logic              illegal_reg;
    logic              trap_bus;
    logic              trap_illegal;

    logic [N_RFUNCT-1:0]      funct_hit;
    logic [N_RFUNCT-1:0][2:0] r_alu_terms;
    logic [2:0]               r_alu_op;
    logic                     r_funct_ok;
    logic                     is_mem_state;
    logic                     timeout;

    // Output strobes before export through the interface
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_inv;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       syscall;
    logic       halted;

    // The zero flag is combined with pc_write_cond/_inv inside the datapath;
    // this unit only issues the conditional strobes.
    logic zero_unused;
    assign zero_unused = bus.zero;

    // One comparator per supported R-type funct, each contributing its ALU op
    generate
        for (genvar gi = 0; gi < N_RFUNCT; gi++) begin : g_rfunct
            assign funct_hit[gi]   = (bus.funct == R_FUNCTS[gi]);
            assign r_alu_terms[gi] = funct_hit[gi] ? R_ALUOPS[gi] : 3'b000;
        end
    endgenerate

    assign r_funct_ok = |funct_hit;

    // Merge the one-hot funct matches into a single ALU op
    always_comb begin
        r_alu_op = 3'b000;
        for (int i = 0; i < N_RFUNCT; i++) begin
            r_alu_op = r_alu_op | r_alu_terms[i];
        end
    end

    assign is_mem_state = (state_reg == S_FETCH) || (state_reg == S_MEM_READ) ||
                          (state_reg == S_MEM_WRITE);
    // A ready on the limit cycle still wins; only a low ready there times out
    assign timeout = TIMEOUT_EN && is_mem_state && !bus.mem_ready &&
                     (wait_reg == WAIT_LIMIT);

    // State register, wait counter and sticky error flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= S_FETCH;
            wait_reg      <= '0;
            bus_error_reg <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (trap_bus) begin
                bus_error_reg <= 1'b1;
            end
            if (trap_illegal) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    // Next-state selection, trap causes and wait counter update
    always_comb begin
        state_next   = state_reg;
        trap_bus     = 1'b0;
        trap_illegal = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    trap_bus   = 1'b1;
                end
            end
            S_DECODE: begin
                if (bus.opcode == OP_RTYPE) begin
                    if (r_funct_ok) begin
                        state_next = S_R_EXEC;
                    end else if (bus.funct == FUNCT_SYSCALL) begin
                        state_next = S_FETCH;
                    end else begin
                        state_next   = S_TRAP;
                        trap_illegal = 1'b1;
                    end
                end else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
                    state_next = S_MEM_ADDR;
                end else if ((bus.opcode == OP_BEQ) ||
                             (ENABLE_BNE && (bus.opcode == OP_BNE))) begin
                    state_next = S_BRANCH;
                end else if (ENABLE_JUMP && (bus.opcode == OP_J)) begin
                    state_next = S_JUMP;
                end else if ((bus.opcode == OP_ADDI) ||
                             (ENABLE_ORI && (bus.opcode == OP_ORI))) begin
                    state_next = S_I_EXEC;
                end else begin
                    state_next   = S_TRAP;
                    trap_illegal = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                state_next = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                if (bus.mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    trap_bus   = 1'b1;
                end
            end
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    trap_bus   = 1'b1;
                end
            end
            S_MEM_WB:  state_next = S_FETCH;
            S_R_EXEC:  state_next = S_R_WB;
            S_R_WB:    state_next = S_FETCH;
            S_BRANCH:  state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
            S_I_EXEC:  state_next = S_I_WB;
            S_I_WB:    state_next = S_FETCH;
            S_TRAP:    state_next = S_TRAP;
            default: begin
                state_next   = S_TRAP;
                trap_illegal = 1'b1;
            end
        endcase

        // Counter restarts on every state change and counts idle memory cycles
        if (state_next != state_reg) begin
            wait_next = '0;
        end else if (is_mem_state && !bus.mem_ready) begin
            wait_next = wait_reg + WAIT_W'(1);
        end else begin
            wait_next = wait_reg;
        end
    end

    // Control strobes decoded from the registered state; forced low in reset
    always_comb begin
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        i_or_d            = 1'b0;
        ir_write          = 1'b0;
        pc_write          = 1'b0;
        pc_write_cond     = 1'b0;
        pc_write_cond_inv = 1'b0;
        pc_source         = 2'b00;
        alu_op            = 3'b000;
        alu_src_a         = 1'b0;
        alu_src_b         = 2'b00;
        zero_ext          = 1'b0;
        reg_write         = 1'b0;
        reg_dst           = 1'b0;
        mem_to_reg        = 1'b0;
        syscall           = 1'b0;
        halted            = 1'b0;
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = ALU_ADD;
                    ir_write  = bus.mem_ready;
                    pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = ALU_ADD;
                    syscall   = (bus.opcode == OP_RTYPE) &&
                                (bus.funct == FUNCT_SYSCALL);
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = ALU_ADD;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = r_alu_op;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a         = 1'b1;
                    alu_op            = ALU_SUB;
                    pc_source         = 2'b01;
                    pc_write_cond     = (bus.opcode == OP_BEQ);
                    pc_write_cond_inv = ENABLE_BNE && (bus.opcode == OP_BNE);
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (ENABLE_ORI && (bus.opcode == OP_ORI)) begin
                        alu_op   = ALU_OR;
                        zero_ext = 1'b1;
                    end else begin
                        alu_op = ALU_ADD;
                    end
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                end
                S_TRAP: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read          = mem_read;
    assign bus.mem_write         = mem_write;
    assign bus.i_or_d            = i_or_d;
    assign bus.ir_write          = ir_write;
    assign bus.pc_write          = pc_write;
    assign bus.pc_write_cond     = pc_write_cond;
    assign bus.pc_write_cond_inv = pc_write_cond_inv;
    assign bus.pc_source         = pc_source;
    assign bus.alu_op            = alu_op;
    assign bus.alu_src_a         = alu_src_a;
    assign bus.alu_src_b         = alu_src_b;
    assign bus.zero_ext          = zero_ext;
    assign bus.reg_write         = reg_write;
    assign bus.reg_dst           = reg_dst;
    assign bus.mem_to_reg        = mem_to_reg;
    assign bus.syscall           = syscall;
    assign bus.halted            = halted;
    assign bus.bus_error         = bus_error_reg & ~reset;
    assign bus.illegal           = illegal_reg & ~reset;
    assign bus.state             = reset ? S_FETCH : state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table walking
// every instruction class, plus hand-written stall, timeout, reset-abort and
// disabled-ORI sequences. Inputs change on the falling edge, outputs are
// checked 1 time unit later.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SYS   = 6'b001100;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus0();
    multicycle_control_if bus1();

    multicycle_control #(
        .ENABLE_BNE(1'b1), .ENABLE_ORI(1'b1), .ENABLE_JUMP(1'b1), .MAX_WAIT(15)
    ) dut (
        .clock(clk), .reset(rst0), .bus(bus0)
    );

    multicycle_control #(
        .ENABLE_BNE(1'b1), .ENABLE_ORI(1'b0), .ENABLE_JUMP(1'b1), .MAX_WAIT(15)
    ) dut_noori (
        .clock(clk), .reset(rst1), .bus(bus1)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [26:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Expected output words:
    // {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
    //  pc_write_cond_inv, pc_source[2], alu_op[3], alu_src_a, alu_src_b[2],
    //  zero_ext, reg_write, reg_dst, mem_to_reg, syscall, bus_error,
    //  illegal, halted, state[4]}
    logic [26:0] E_RST, E_FETCH, E_FETCH_W, E_DEC, E_DEC_SYS, E_MADDR, E_MRD;
    logic [26:0] E_MWB, E_MWR, E_RADD, E_RSUB, E_RSLT, E_RWB, E_BEQ, E_BNE;
    logic [26:0] E_JMP, E_ADDI, E_ORI, E_IWB, E_TRAP_IL, E_TRAP_BE;

    function automatic logic [26:0] mk(
        input logic mr, mw, iod, irw, pcw, pcc, pcci,
        input logic [1:0] pcs, input logic [2:0] aop,
        input logic asa, input logic [1:0] asb,
        input logic zx, rw, rd, m2r, sys, be, il, hl,
        input logic [3:0] st);
        return {mr, mw, iod, irw, pcw, pcc, pcci, pcs, aop, asa, asb,
                zx, rw, rd, m2r, sys, be, il, hl, st};
    endfunction

    function automatic logic [26:0] get0();
        return {bus0.mem_read, bus0.mem_write, bus0.i_or_d, bus0.ir_write,
                bus0.pc_write, bus0.pc_write_cond, bus0.pc_write_cond_inv,
                bus0.pc_source, bus0.alu_op, bus0.alu_src_a, bus0.alu_src_b,
                bus0.zero_ext, bus0.reg_write, bus0.reg_dst, bus0.mem_to_reg,
                bus0.syscall, bus0.bus_error, bus0.illegal, bus0.halted,
                bus0.state};
    endfunction

    function automatic logic [26:0] get1();
        return {bus1.mem_read, bus1.mem_write, bus1.i_or_d, bus1.ir_write,
                bus1.pc_write, bus1.pc_write_cond, bus1.pc_write_cond_inv,
                bus1.pc_source, bus1.alu_op, bus1.alu_src_a, bus1.alu_src_b,
                bus1.zero_ext, bus1.reg_write, bus1.reg_dst, bus1.mem_to_reg,
                bus1.syscall, bus1.bus_error, bus1.illegal, bus1.halted,
                bus1.state};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [26:0] exp,
                       input string name);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
        v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // One cycle on the main DUT: drive after the falling edge, settle 1 unit
    task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy);
        @(negedge clk);
        rst0 = rst;
        bus0.opcode = op;
        bus0.funct = fn;
        bus0.zero = z;
        bus0.mem_ready = rdy;
        #1;
    endtask

    initial begin
        int ir_cnt;
        int mw_cycles;

        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.opcode = '0; bus0.funct = '0; bus0.zero = 1'b0; bus0.mem_ready = 1'b0;
        bus1.opcode = '0; bus1.funct = '0; bus1.zero = 1'b0; bus1.mem_ready = 1'b0;

        E_RST     = '0;
        E_FETCH   = mk(1,0,0,1,1,0,0,2'b00,3'b010,0,2'b01,0,0,0,0,0,0,0,0,4'd0);
        E_FETCH_W = mk(1,0,0,0,0,0,0,2'b00,3'b010,0,2'b01,0,0,0,0,0,0,0,0,4'd0);
        E_DEC     = mk(0,0,0,0,0,0,0,2'b00,3'b010,0,2'b11,0,0,0,0,0,0,0,0,4'd1);
        E_DEC_SYS = mk(0,0,0,0,0,0,0,2'b00,3'b010,0,2'b11,0,0,0,0,1,0,0,0,4'd1);
        E_MADDR   = mk(0,0,0,0,0,0,0,2'b00,3'b010,1,2'b10,0,0,0,0,0,0,0,0,4'd2);
        E_MRD     = mk(1,0,1,0,0,0,0,2'b00,3'b000,0,2'b00,0,0,0,0,0,0,0,0,4'd3);
        E_MWB     = mk(0,0,0,0,0,0,0,2'b00,3'b000,0,2'b00,0,1,0,1,0,0,0,0,4'd4);
        E_MWR     = mk(0,1,1,0,0,0,0,2'b00,3'b000,0,2'b00,0,0,0,0,0,0,0,0,4'd5);
        E_RADD    = mk(0,0,0,0,0,0,0,2'b00,3'b010,1,2'b00,0,0,0,0,0,0,0,0,4'd6);
        E_RSUB    = mk(0,0,0,0,0,0,0,2'b00,3'b110,1,2'b00,0,0,0,0,0,0,0,0,4'd6);
        E_RSLT    = mk(0,0,0,0,0,0,0,2'b00,3'b111,1,2'b00,0,0,0,0,0,0,0,0,4'd6);
        E_RWB     = mk(0,0,0,0,0,0,0,2'b00,3'b000,0,2'b00,0,1,1,0,0,0,0,0,4'd7);
        E_BEQ     = mk(0,0,0,0,0,1,0,2'b01,3'b110,1,2'b00,0,0,0,0,0,0,0,0,4'd8);
        E_BNE     = mk(0,0,0,0,0,0,1,2'b01,3'b110,1,2'b00,0,0,0,0,0,0,0,0,4'd8);
        E_JMP     = mk(0,0,0,0,1,0,0,2'b10,3'b000,0,2'b00,0,0,0,0,0,0,0,0,4'd9);
        E_ADDI    = mk(0,0,0,0,0,0,0,2'b00,3'b010,1,2'b10,0,0,0,0,0,0,0,0,4'd10);
        E_ORI     = mk(0,0,0,0,0,0,0,2'b00,3'b001,1,2'b10,1,0,0,0,0,0,0,0,4'd10);
        E_IWB     = mk(0,0,0,0,0,0,0,2'b00,3'b000,0,2'b00,0,1,0,0,0,0,0,0,4'd11);
        E_TRAP_IL = mk(0,0,0,0,0,0,0,2'b00,3'b000,0,2'b00,0,0,0,0,0,0,1,1,4'd12);
        E_TRAP_BE = mk(0,0,0,0,0,0,0,2'b00,3'b000,0,2'b00,0,0,0,0,0,1,0,1,4'd12);

        // ---------------- vector table, one row per clock ----------------
        add(1, OP_LW, 0, 0, 0, E_RST, "reset");
        add(1, OP_LW, 0, 0, 1, E_RST, "reset_ready");
        add(0, OP_LW, 0, 0, 1, E_FETCH, "lw_fetch");
        add(0, OP_LW, 0, 0, 1, E_DEC, "lw_decode");
        add(0, OP_LW, 0, 0, 1, E_MADDR, "lw_maddr");
        add(0, OP_LW, 0, 0, 1, E_MRD, "lw_mread");
        add(0, OP_LW, 0, 0, 1, E_MWB, "lw_mwb");
        add(0, OP_R, F_ADD, 0, 1, E_FETCH, "add_fetch");
        add(0, OP_R, F_ADD, 0, 1, E_DEC, "add_decode");
        add(0, OP_R, F_ADD, 0, 1, E_RADD, "add_exec");
        add(0, OP_R, F_ADD, 0, 1, E_RWB, "add_wb");
        add(0, OP_R, F_SUB, 0, 1, E_FETCH, "sub_fetch");
        add(0, OP_R, F_SUB, 0, 1, E_DEC, "sub_decode");
        add(0, OP_R, F_SUB, 0, 1, E_RSUB, "sub_exec");
        add(0, OP_R, F_SUB, 0, 1, E_RWB, "sub_wb");
        add(0, OP_R, F_SLT, 0, 1, E_FETCH, "slt_fetch");
        add(0, OP_R, F_SLT, 0, 1, E_DEC, "slt_decode");
        add(0, OP_R, F_SLT, 0, 1, E_RSLT, "slt_exec");
        add(0, OP_R, F_SLT, 0, 1, E_RWB, "slt_wb");
        add(0, OP_SW, 0, 0, 1, E_FETCH, "sw_fetch");
        add(0, OP_SW, 0, 0, 1, E_DEC, "sw_decode");
        add(0, OP_SW, 0, 0, 1, E_MADDR, "sw_maddr");
        add(0, OP_SW, 0, 0, 1, E_MWR, "sw_mwrite");
        add(0, OP_BEQ, 0, 1, 1, E_FETCH, "beq_fetch");
        add(0, OP_BEQ, 0, 1, 1, E_DEC, "beq_decode");
        add(0, OP_BEQ, 0, 1, 1, E_BEQ, "beq_branch");
        add(0, OP_BNE, 0, 0, 1, E_FETCH, "bne_fetch");
        add(0, OP_BNE, 0, 0, 1, E_DEC, "bne_decode");
        add(0, OP_BNE, 0, 0, 1, E_BNE, "bne_branch");
        add(0, OP_J, 0, 0, 1, E_FETCH, "j_fetch");
        add(0, OP_J, 0, 0, 1, E_DEC, "j_decode");
        add(0, OP_J, 0, 0, 1, E_JMP, "j_jump");
        add(0, OP_ADDI, 0, 0, 1, E_FETCH, "addi_fetch");
        add(0, OP_ADDI, 0, 0, 1, E_DEC, "addi_decode");
        add(0, OP_ADDI, 0, 0, 1, E_ADDI, "addi_exec");
        add(0, OP_ADDI, 0, 0, 1, E_IWB, "addi_wb");
        add(0, OP_ORI, 0, 0, 1, E_FETCH, "ori_fetch");
        add(0, OP_ORI, 0, 0, 1, E_DEC, "ori_decode");
        add(0, OP_ORI, 0, 0, 1, E_ORI, "ori_exec");
        add(0, OP_ORI, 0, 0, 1, E_IWB, "ori_wb");
        add(0, OP_R, F_SYS, 0, 1, E_FETCH, "sys_fetch");
        add(0, OP_R, F_SYS, 0, 1, E_DEC_SYS, "sys_decode");
        add(0, OP_R, F_SYS, 0, 1, E_FETCH, "sys_next_fetch");
        add(0, OP_R, 6'b000000, 0, 1, E_DEC, "badfn_decode");
        add(0, OP_R, 6'b000000, 0, 1, E_TRAP_IL, "badfn_trap");
        add(0, OP_R, 6'b000000, 0, 1, E_TRAP_IL, "badfn_trap_hold");
        add(1, OP_R, 6'b000000, 0, 1, E_RST, "trap_reset");
        add(1, OP_LW, 0, 0, 0, E_RST, "trap_reset2");

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy);
            $display("vec %0d %s state=%0d ctl=%h", i, vecs[i].name, bus0.state, get0());
            check(vecs[i].name, {5'd0, get0()}, {5'd0, vecs[i].exp});
        end

        // ---------------- fetch stalled 3 cycles ----------------
        ir_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            cyc(0, OP_SW, 0, 0, (c == 3));
            $display("stall cycle %0d state=%0d ir_write=%0b", c, bus0.state, bus0.ir_write);
            check("stall_fetch_state", {28'd0, bus0.state}, 32'd0);
            ir_cnt += int'(bus0.ir_write);
        end
        check("stall_ir_write_once", ir_cnt, 1);
        cyc(0, OP_SW, 0, 0, 1);
        check("stall_then_decode", {5'd0, get0()}, {5'd0, E_DEC});
        cyc(0, OP_SW, 0, 0, 0);
        check("to_maddr", {5'd0, get0()}, {5'd0, E_MADDR});

        // ---------------- MEM_WRITE timeout ----------------
        mw_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(0, OP_SW, 0, 0, 0);
            if (bus0.state == 4'd5 && bus0.mem_write) begin
                mw_cycles++;
            end else begin
                break;
            end
        end
        $display("mem_write held %0d cycles before state=%0d", mw_cycles, bus0.state);
        check("timeout_wait_cycles", mw_cycles, 16);
        check("timeout_trap", {5'd0, get0()}, {5'd0, E_TRAP_BE});
        cyc(0, OP_SW, 0, 0, 1);
        check("trap_ignores_ready", {5'd0, get0()}, {5'd0, E_TRAP_BE});
        cyc(1, OP_LW, 0, 0, 1);
        check("timeout_reset_clear", {5'd0, get0()}, {5'd0, E_RST});

        // ---------------- ready exactly on the limit cycle ----------------
        for (int c = 0; c < 15; c++) begin
            cyc(0, OP_LW, 0, 0, 0);
            check("limit_wait_fetch", {5'd0, get0()}, {5'd0, E_FETCH_W});
        end
        cyc(0, OP_LW, 0, 0, 1);
        check("limit_ready_success", {5'd0, get0()}, {5'd0, E_FETCH});
        cyc(0, OP_LW, 0, 0, 1);
        check("limit_decode", {5'd0, get0()}, {5'd0, E_DEC});

        // ---------------- reset mid-instruction ----------------
        cyc(0, OP_LW, 0, 0, 0);
        check("abort_maddr", {5'd0, get0()}, {5'd0, E_MADDR});
        cyc(0, OP_LW, 0, 0, 0);
        check("abort_mread", {5'd0, get0()}, {5'd0, E_MRD});
        cyc(1, OP_LW, 0, 0, 1);
        check("abort_reset_outputs", {5'd0, get0()}, {5'd0, E_RST});
        cyc(0, OP_LW, 0, 0, 1);
        $display("after abort state=%0d reg_write=%0b", bus0.state, bus0.reg_write);
        check("abort_back_to_fetch", {5'd0, get0()}, {5'd0, E_FETCH});

        // ---------------- ENABLE_ORI=0 instance ----------------
        @(negedge clk);
        rst1 = 1'b0;
        bus1.opcode = OP_ORI;
        bus1.funct = 6'b000000;
        bus1.mem_ready = 1'b1;
        #1;
        check("noori_fetch", {5'd0, get1()}, {5'd0, E_FETCH});
        @(negedge clk);
        #1;
        check("noori_decode", {5'd0, get1()}, {5'd0, E_DEC});
        @(negedge clk);
        #1;
        $display("noori state=%0d illegal=%0b halted=%0b", bus1.state, bus1.illegal, bus1.halted);
        check("noori_trap", {5'd0, get1()}, {5'd0, E_TRAP_IL});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle control unit, the successor to the single-cycle decoder. It sequences fetch, decode, execute, memory and write-back for one instruction at a time over a shared datapath and a single instruction/data memory port. It stalls on a memory ready handshake, times out stuck accesses, and traps on illegal instructions. Optional instruction groups are enabled at elaboration time.

## Interface
Parameters:
- ENABLE_BNE, 1: decode opcode 000101 (bne); when 0 it is illegal.
- ENABLE_ORI, 1: decode opcode 001101 (ori, zero-extended immediate); when 0 it is illegal.
- ENABLE_JUMP, 1: decode opcode 000010 (j); when 0 it is illegal.
- MAX_WAIT, 15: maximum cycles to wait for mem_ready per access; 0 disables the timeout.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction[31:26] from the instruction register.
- funct  in  6  instruction[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_read, mem_write  out  1  memory request strobes, held until mem_ready.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero (beq).
- pc_write_cond_inv  out  1  PC load if !zero (bne).
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_op  out  3  010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- zero_ext  out  1  immediate is zero-extended (ori).
- reg_write, reg_dst, mem_to_reg  out  1  register file write, rd/rt select, memory/ALU select.
- syscall  out  1  one-cycle pulse on a decoded syscall.
- bus_error  out  1  sticky; set on memory timeout.
- illegal  out  1  sticky; set on an undecodable instruction.
- halted  out  1  high while the unit is in TRAP.
- state  out  4  current state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, TRAP 12. Encodings 13–15 go to TRAP with illegal=1.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00. On mem_ready, ir_write and pc_write pulse for that cycle, then go to DECODE. Without mem_ready, stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (branch target into ALUOut). Next state by opcode:
  - 000000 with funct add 100000, sub 100010, and 100100, or 100101, slt 101010 -> R_EXEC.
  - funct 001100 -> syscall pulses, next is FETCH.
  - Other funct -> TRAP.
  - 100011 or 101011 -> MEM_ADDR.
  - 000100, or 000101 if ENABLE_BNE -> BRANCH.
  - 000010 if ENABLE_JUMP -> JUMP.
  - 001000, or 001101 if ENABLE_ORI -> I_EXEC.
  - Anything else -> TRAP with illegal=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. On mem_ready go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. On mem_ready go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op from funct -> R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_source=01. beq asserts pc_write_cond; bne asserts pc_write_cond_inv. Next is FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. addi uses add with zero_ext=0; ori uses or with zero_ext=1. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- TRAP: all strobes are 0, halted=1. It is left only by reset.
- Wait counter: cleared on entry to each memory state and incremented each cycle mem_ready is low. If it reaches MAX_WAIT while mem_ready is still low (and MAX_WAIT≠0), the unit goes to TRAP with bus_error=1. mem_ready on the same cycle the counter hits MAX_WAIT counts as success.
- Any output not listed for a state is 0.

## Timing
- Reset: while reset is high, every output is 0 and state=FETCH. bus_error, illegal, halted, syscall and the wait counter are cleared. The first request is on the cycle after reset deasserts.
- Outputs are decoded combinationally from the registered state. ir_write, pc_write (FETCH) and the handshake exits are also qualified by mem_ready.
- Cycles per instruction with mem_ready tied high: lw 5, sw 4, R-type 4, addi/ori 4, beq/bne 3, j 3, syscall 2. Each cycle mem_ready is low adds one cycle.
- Reset asserted mid-instruction aborts it on the next edge. No partial write occurs after that edge.
- mem_ready outside a memory state is ignored.

## Test plan
- Reset, then lw with mem_ready=1 -> states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. Total 5 cycles.
- beq with zero=1, then bne with zero=0 -> pc_write_cond=1 in state 8 for beq, pc_write_cond_inv=1 for bne. The other strobe stays 0.
- Fetch with mem_ready low for 3 cycles (MAX_WAIT=15) -> FETCH held 4 cycles. ir_write pulses exactly once, on the ready cycle.
- mem_ready held low during MEM_WRITE -> TRAP after 15 wait cycles. bus_error=1, halted=1, mem_write=0 thereafter, until reset clears everything.
- ENABLE_ORI=0 with opcode 001101, and opcode 000000 with funct 000000 -> TRAP, illegal=1. With ENABLE_ORI=1, ori gives zero_ext=1, alu_op=001.
- syscall (funct 001100) -> syscall high for exactly one cycle in DECODE, then FETCH. No reg_write.
